// File: rtl/pic_priority_core.sv
// pic_priority_core: NUM_IRQ-channel interrupt priority core with IRR/ISR/IMR,
// fully nested or rotating priority, two-pulse INTA handshake, AEOI and OCW2-style EOI.
module pic_priority_core #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_IRQ-1:0] requests,
  input  logic               icw_we,
  input  logic               icw_aeoi,
  input  logic               icw_level,
  input  logic               imr_we,
  input  logic [NUM_IRQ-1:0] imr_wdata,
  input  logic               ocw2_we,
  input  logic [2:0]         ocw2_cmd,
  input  logic [IDX_W-1:0]   ocw2_level,
  input  logic               inta,
  output logic               int_out,
  output logic [IDX_W-1:0]   vector,
  output logic               vector_valid,
  output logic [NUM_IRQ-1:0] irr,
  output logic [NUM_IRQ-1:0] isr,
  output logic [NUM_IRQ-1:0] imr
);

  // One extra bit so p + NUM_IRQ - lowest - 1 never overflows for any channel count.
  localparam int RW = IDX_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACK1 = 2'd1, ACK2 = 2'd2} state_t;

  // Out-of-range indices shift out to all-zero, which doubles as the range check.
  function automatic logic [NUM_IRQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NUM_IRQ'(1) << idx;
  endfunction

  function automatic logic [RW-1:0] rank_of(input logic [IDX_W-1:0] p,
                                            input logic [IDX_W-1:0] low);
    logic [RW-1:0] r;
    r = RW'(p) + RW'(NUM_IRQ) - RW'(low) - RW'(1);
    if (r >= RW'(NUM_IRQ)) r = r - RW'(NUM_IRQ);
    return r;
  endfunction

  // Returns {found, index} of the set bit with the smallest rank.
  function automatic logic [IDX_W:0] pick_best(input logic [NUM_IRQ-1:0] bits,
                                               input logic [IDX_W-1:0]   low);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [RW-1:0]    best_rk;
    logic [RW-1:0]    rk;
    found   = 1'b0;
    idx     = '0;
    best_rk = '0;
    for (int p = 0; p < NUM_IRQ; p++) begin
      rk = rank_of(IDX_W'(p), low);
      if (bits[p] && (!found || rk < best_rk)) begin
        found   = 1'b1;
        idx     = IDX_W'(p);
        best_rk = rk;
      end
    end
    return {found, idx};
  endfunction

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] req_q, req_d;
  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] imr_q, imr_d;
  logic [IDX_W-1:0]   lowest_q, lowest_d;
  logic               aeoi_q, aeoi_d;
  logic               level_q, level_d;
  logic               rot_aeoi_q, rot_aeoi_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic               spurious_q, spurious_d;
  logic               int_out_q, int_out_d;
  logic [IDX_W-1:0]   vector_q, vector_d;
  logic               vector_valid_q, vector_valid_d;

  logic               cand_found, isr_found;
  logic [IDX_W-1:0]   cand_idx, isr_top;
  logic [RW-1:0]      cand_rank, isr_rank;
  logic [NUM_IRQ-1:0] eoi_clr, ack_set, irr_clr, lvl_hot;

  // Resolver, handshake sequencing and command decode; ocw2 priority changes
  // are decoded after the handshake so an explicit command wins over AEOI rotation.
  always_comb begin
    state_d        = state_q;
    req_d          = requests;
    imr_d          = imr_we ? imr_wdata : imr_q;
    aeoi_d         = icw_we ? icw_aeoi : aeoi_q;
    level_d        = icw_we ? icw_level : level_q;
    lowest_d       = lowest_q;
    rot_aeoi_d     = rot_aeoi_q;
    sel_d          = sel_q;
    spurious_d     = spurious_q;
    vector_d       = vector_q;
    vector_valid_d = 1'b0;
    eoi_clr        = '0;
    ack_set        = '0;
    irr_clr        = '0;
    lvl_hot        = onehot(ocw2_level);

    {cand_found, cand_idx} = pick_best(irr_q & ~imr_q, lowest_q);
    {isr_found, isr_top}   = pick_best(isr_q, lowest_q);
    cand_rank              = rank_of(cand_idx, lowest_q);
    isr_rank               = rank_of(isr_top, lowest_q);

    case (state_q)
      IDLE: begin
        if (inta) begin
          state_d = ACK1;
          if (cand_found) begin
            sel_d      = cand_idx;
            spurious_d = 1'b0;
            ack_set    = onehot(cand_idx);
            irr_clr    = onehot(cand_idx);
          end else begin
            sel_d      = IDX_W'(NUM_IRQ - 1);
            spurious_d = 1'b1;
          end
        end
      end
      ACK1: begin
        if (inta) begin
          state_d        = ACK2;
          vector_d       = sel_q;
          vector_valid_d = 1'b1;
          if (aeoi_q && !spurious_q) begin
            eoi_clr = onehot(sel_q);
            if (rot_aeoi_q) lowest_d = sel_q;
          end
        end
      end
      ACK2:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (ocw2_we) begin
      case (ocw2_cmd)
        3'b001: if (isr_found) eoi_clr = eoi_clr | onehot(isr_top);
        3'b011: eoi_clr = eoi_clr | lvl_hot;
        3'b101: begin
          if (isr_found) begin
            eoi_clr  = eoi_clr | onehot(isr_top);
            lowest_d = isr_top;
          end
        end
        3'b111: begin
          if (|lvl_hot) begin
            eoi_clr  = eoi_clr | lvl_hot;
            lowest_d = ocw2_level;
          end
        end
        3'b110:  if (|lvl_hot) lowest_d = ocw2_level;
        3'b100:  rot_aeoi_d = 1'b1;
        3'b000:  rot_aeoi_d = 1'b0;
        default: ;
      endcase
    end

    isr_d = (isr_q & ~eoi_clr) | ack_set;

    if (level_q) irr_d = requests;
    else         irr_d = (irr_q & ~irr_clr) | (requests & ~req_q);

    int_out_d = (state_d == IDLE) && cand_found && (!isr_found || cand_rank < isr_rank);
  end

  // State registers with synchronous reset; reset aborts any handshake in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= IDLE;
      req_q          <= '0;
      irr_q          <= '0;
      isr_q          <= '0;
      imr_q          <= '0;
      lowest_q       <= IDX_W'(NUM_IRQ - 1);
      aeoi_q         <= 1'b0;
      level_q        <= 1'b0;
      rot_aeoi_q     <= 1'b0;
      sel_q          <= '0;
      spurious_q     <= 1'b0;
      int_out_q      <= 1'b0;
      vector_q       <= '0;
      vector_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      irr_q          <= irr_d;
      isr_q          <= isr_d;
      imr_q          <= imr_d;
      lowest_q       <= lowest_d;
      aeoi_q         <= aeoi_d;
      level_q        <= level_d;
      rot_aeoi_q     <= rot_aeoi_d;
      sel_q          <= sel_d;
      spurious_q     <= spurious_d;
      int_out_q      <= int_out_d;
      vector_q       <= vector_d;
      vector_valid_q <= vector_valid_d;
    end
  end

  assign int_out      = int_out_q;
  assign vector       = vector_q;
  assign vector_valid = vector_valid_q;
  assign irr          = irr_q;
  assign isr          = isr_q;
  assign imr          = imr_q;

endmodule

// File: tb/tb_pic_priority_core.sv
// tb_pic_priority_core: drives an 8-channel and a 12-channel core from shared
// stimulus and compares both against a behavioural priority model every cycle.
module tb_pic_priority_core;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] req_bus = '0;
  logic        icw_we = 1'b0, icw_aeoi = 1'b0, icw_level = 1'b0;
  logic        imr_we = 1'b0;
  logic [11:0] imr_wdata = '0;
  logic        ocw2_we = 1'b0;
  logic [2:0]  ocw2_cmd = '0;
  logic [3:0]  ocw2_level_bus = '0;
  logic        inta = 1'b0;

  logic        int_out8, vv8, int_out12, vv12;
  logic [2:0]  vector8;
  logic [3:0]  vector12;
  logic [7:0]  irr8, isr8, imr8;
  logic [11:0] irr12, isr12, imr12;

  int total_count = 0;
  int bad_count   = 0;

  // Behavioural model state, index 0 = 8 channels, index 1 = 12 channels.
  int m_irr[2], m_isr[2], m_imr[2], m_req_prev[2], m_lowest[2];
  int m_aeoi[2], m_lvl[2], m_rot[2], m_phase[2], m_sel[2], m_spur[2];
  int m_int[2], m_vec[2], m_vv[2];

  pic_priority_core #(.NUM_IRQ(8)) u8 (
    .CLK(CLK), .RST(rst), .requests(req_bus[7:0]),
    .icw_we(icw_we), .icw_aeoi(icw_aeoi), .icw_level(icw_level),
    .imr_we(imr_we), .imr_wdata(imr_wdata[7:0]),
    .ocw2_we(ocw2_we), .ocw2_cmd(ocw2_cmd), .ocw2_level(ocw2_level_bus[2:0]),
    .inta(inta), .int_out(int_out8), .vector(vector8), .vector_valid(vv8),
    .irr(irr8), .isr(isr8), .imr(imr8)
  );

  pic_priority_core #(.NUM_IRQ(12)) u12 (
    .CLK(CLK), .RST(rst), .requests(req_bus),
    .icw_we(icw_we), .icw_aeoi(icw_aeoi), .icw_level(icw_level),
    .imr_we(imr_we), .imr_wdata(imr_wdata),
    .ocw2_we(ocw2_we), .ocw2_cmd(ocw2_cmd), .ocw2_level(ocw2_level_bus),
    .inta(inta), .int_out(int_out12), .vector(vector12), .vector_valid(vv12),
    .irr(irr12), .isr(isr12), .imr(imr12)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total_count++;
    if (observed != expected) begin
      bad_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int rankOf(input int p, input int low, input int n);
    return (p - low - 1 + 2 * n) % n;
  endfunction

  function automatic int bestOf(input int bits, input int low, input int n);
    int b = -1;
    for (int p = 0; p < n; p++)
      if (((bits >> p) & 1) != 0 && (b < 0 || rankOf(p, low, n) < rankOf(b, low, n))) b = p;
    return b;
  endfunction

  // One clock of the reference model, using the inputs present before the edge.
  task automatic modelStep(input int k);
    int n, mask, req, lvl_in, cand, top, clr, setb, irr_clr;
    int n_phase, n_sel, n_spur, n_vec, n_vv, n_low, n_rot;
    n      = (k == 0) ? 8 : 12;
    mask   = (1 << n) - 1;
    req    = int'(req_bus) & mask;
    lvl_in = int'(ocw2_level_bus) & ((k == 0) ? 7 : 15);
    if (rst) begin
      m_irr[k] = 0; m_isr[k] = 0; m_imr[k] = 0; m_req_prev[k] = 0; m_lowest[k] = n - 1;
      m_aeoi[k] = 0; m_lvl[k] = 0; m_rot[k] = 0; m_phase[k] = 0; m_sel[k] = 0;
      m_spur[k] = 0; m_int[k] = 0; m_vec[k] = 0; m_vv[k] = 0;
      return;
    end
    cand = bestOf(m_irr[k] & ~m_imr[k], m_lowest[k], n);
    top  = bestOf(m_isr[k], m_lowest[k], n);
    clr = 0; setb = 0; irr_clr = 0;
    n_phase = m_phase[k]; n_sel = m_sel[k]; n_spur = m_spur[k];
    n_vec = m_vec[k]; n_vv = 0; n_low = m_lowest[k]; n_rot = m_rot[k];
    if (m_phase[k] == 0 && inta) begin
      n_phase = 1;
      if (cand >= 0) begin
        n_sel = cand; n_spur = 0; setb = 1 << cand; irr_clr = 1 << cand;
      end else begin
        n_sel = n - 1; n_spur = 1;
      end
    end else if (m_phase[k] == 1 && inta) begin
      n_phase = 2; n_vec = m_sel[k]; n_vv = 1;
      if (m_aeoi[k] != 0 && m_spur[k] == 0) begin
        clr = clr | (1 << m_sel[k]);
        if (m_rot[k] != 0) n_low = m_sel[k];
      end
    end else if (m_phase[k] == 2) begin
      n_phase = 0;
    end
    if (ocw2_we) begin
      case (ocw2_cmd)
        3'b001: if (top >= 0) clr = clr | (1 << top);
        3'b011: if (lvl_in < n) clr = clr | (1 << lvl_in);
        3'b101: if (top >= 0) begin clr = clr | (1 << top); n_low = top; end
        3'b111: if (lvl_in < n) begin clr = clr | (1 << lvl_in); n_low = lvl_in; end
        3'b110: if (lvl_in < n) n_low = lvl_in;
        3'b100: n_rot = 1;
        3'b000: n_rot = 0;
        default: ;
      endcase
    end
    m_int[k] = (n_phase == 0 && cand >= 0 &&
                (top < 0 || rankOf(cand, m_lowest[k], n) < rankOf(top, m_lowest[k], n))) ? 1 : 0;
    m_isr[k] = (m_isr[k] & ~clr) | setb;
    m_irr[k] = (m_lvl[k] != 0) ? req : (((m_irr[k] & ~irr_clr) | (req & ~m_req_prev[k])) & mask);
    m_req_prev[k] = req;
    m_phase[k] = n_phase; m_sel[k] = n_sel; m_spur[k] = n_spur;
    m_vec[k] = n_vec; m_vv[k] = n_vv; m_lowest[k] = n_low; m_rot[k] = n_rot;
    if (icw_we) begin m_aeoi[k] = int'(icw_aeoi); m_lvl[k] = int'(icw_level); end
    if (imr_we) m_imr[k] = int'(imr_wdata) & mask;
  endtask

  // Advance one clock, update the model, compare all outputs, drop strobes.
  task automatic tick();
    @(posedge CLK);
    modelStep(0);
    modelStep(1);
    #1;
    checkOutput("u8.int",  int'(int_out8), m_int[0]);
    checkOutput("u8.vv",   int'(vv8),      m_vv[0]);
    checkOutput("u8.vec",  int'(vector8),  m_vec[0]);
    checkOutput("u8.irr",  int'(irr8),     m_irr[0]);
    checkOutput("u8.isr",  int'(isr8),     m_isr[0]);
    checkOutput("u8.imr",  int'(imr8),     m_imr[0]);
    checkOutput("u12.int", int'(int_out12), m_int[1]);
    checkOutput("u12.vv",  int'(vv12),      m_vv[1]);
    checkOutput("u12.vec", int'(vector12),  m_vec[1]);
    checkOutput("u12.irr", int'(irr12),     m_irr[1]);
    checkOutput("u12.isr", int'(isr12),     m_isr[1]);
    checkOutput("u12.imr", int'(imr12),     m_imr[1]);
    inta = 1'b0; icw_we = 1'b0; imr_we = 1'b0; ocw2_we = 1'b0; rst = 1'b0;
  endtask

  task automatic applyReset();
    rst = 1'b1; req_bus = '0;
    tick();
    checkOutput("rst.isr8",  int'(isr8),  0);
    checkOutput("rst.irr12", int'(irr12), 0);
  endtask

  // First INTA, one idle cycle, second INTA; returns with vector_valid visible.
  task automatic ackCycle();
    inta = 1'b1; tick();
    tick();
    inta = 1'b1; tick();
  endtask

  task automatic issueOcw2(input logic [2:0] cmd, input logic [3:0] lvl);
    ocw2_we = 1'b1; ocw2_cmd = cmd; ocw2_level_bus = lvl;
    tick();
  endtask

  task automatic applyStimulus();
    if ($urandom_range(0, 2) == 0) req_bus = req_bus ^ (12'd1 << $urandom_range(0, 11));
    inta = ($urandom_range(0, 3) == 0);
    if ($urandom_range(0, 11) == 0) begin
      ocw2_we = 1'b1;
      ocw2_cmd = 3'($urandom_range(0, 7));
      ocw2_level_bus = 4'($urandom_range(0, 15));
    end
    if ($urandom_range(0, 29) == 0) begin
      imr_we = 1'b1;
      imr_wdata = 12'($urandom & $urandom);
    end
    if ($urandom_range(0, 59) == 0) begin
      icw_we = 1'b1;
      icw_aeoi = 1'($urandom_range(0, 1));
      icw_level = 1'($urandom_range(0, 1));
    end
    if ($urandom_range(0, 399) == 0) rst = 1'b1;
    tick();
  endtask

  initial begin
    applyReset();

    // Simultaneous rising requests on 3 and 5; 3 outranks 5 under reset priority.
    req_bus = 12'h028; tick(); tick();
    checkOutput("t1.int", int'(int_out8), 1);
    ackCycle();
    checkOutput("t1.vv",  int'(vv8),     1);
    checkOutput("t1.vec", int'(vector8), 3);
    checkOutput("t1.isr", int'(isr8),    8'h08);
    checkOutput("t1.irr", int'(irr8),    8'h20);
    tick();

    // Nesting: lower priority 6 is held off, higher priority 1 breaks through.
    applyReset();
    req_bus = 12'h008; tick(); tick();
    ackCycle(); tick();
    req_bus = 12'h048; tick(); tick(); tick();
    checkOutput("t2.hold", int'(int_out8), 0);
    req_bus = 12'h04a; tick(); tick();
    checkOutput("t2.nest", int'(int_out8), 1);
    applyReset();
    req_bus = 12'h008; tick(); tick();
    ackCycle(); tick();
    req_bus = 12'h048; tick(); tick();
    checkOutput("t2.hold6", int'(int_out8), 0);
    issueOcw2(3'b001, 4'd0); tick();
    checkOutput("t2.eoi", int'(int_out8), 1);

    // Rotate-on-EOI makes 3 lowest, so 4 beats 2.
    applyReset();
    req_bus = 12'h008; tick(); tick();
    ackCycle(); tick();
    issueOcw2(3'b101, 4'd0);
    checkOutput("t3.isr", int'(isr8), 0);
    req_bus = 12'h01c; tick(); tick();
    ackCycle();
    checkOutput("t3.vec8",  int'(vector8),  4);
    checkOutput("t3.vec12", int'(vector12), 4);
    tick();

    // AEOI with rotation: servicing 0 clears ISR and makes 0 lowest.
    applyReset();
    icw_we = 1'b1; icw_aeoi = 1'b1; icw_level = 1'b0; tick();
    issueOcw2(3'b100, 4'd0);
    req_bus = 12'h001; tick(); tick();
    ackCycle();
    checkOutput("t4.vec", int'(vector8), 0);
    checkOutput("t4.isr", int'(isr8),    0);
    tick();
    req_bus = 12'h000; tick();
    req_bus = 12'h003; tick(); tick();
    ackCycle();
    checkOutput("t4.rot", int'(vector8), 1);
    tick();

    // Spurious: level request withdrawn before the first INTA.
    applyReset();
    icw_we = 1'b1; icw_aeoi = 1'b0; icw_level = 1'b1; tick();
    req_bus = 12'h004; tick(); tick();
    checkOutput("t5.int", int'(int_out8), 1);
    req_bus = 12'h000; tick();
    ackCycle();
    checkOutput("t5.vec8",  int'(vector8),  7);
    checkOutput("t5.vec12", int'(vector12), 11);
    checkOutput("t5.isr",   int'(isr8),     0);
    tick();

    // Reset in the middle of a handshake, then the lowest channel of 12.
    applyReset();
    req_bus = 12'h800; tick(); tick();
    inta = 1'b1; tick();
    rst = 1'b1; tick();
    checkOutput("t6.vv",  int'(vv12),  0);
    checkOutput("t6.isr", int'(isr12), 0);
    tick();
    checkOutput("t6.vv2", int'(vv12),  0);
    req_bus = 12'h000; tick();
    req_bus = 12'h800; tick(); tick();
    ackCycle();
    checkOutput("t6.vec", int'(vector12), 11);
    tick();

    // Randomised traffic against the model.
    applyReset();
    for (int i = 0; i < 4000; i++) applyStimulus();

    $display("test done: total=%0d bad=%0d", total_count, bad_count);
    $finish;
  end

endmodule
